mem: RTL and testbench
======================

Name: mem

Overview:
- MEM pipeline stage, directly downstream of EX (through the EX/MEM latch).
- Converts one load/store request (enable, r/w, width, signedness, address, store data) into a little-endian byte-serial sequence on an 8-bit synchronous RAM port.
- Sign/zero-extends load results and presents the writeback triple plus a forwarding copy.
- Holds the pipeline with stall_req_o while an access is in flight. Non-memory instructions pass through with zero latency.

Parameters:
- ADDR_W, 32, width of request address and RAM address.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- we_i  in  1  writeback enable from EX/MEM
- wd_i  in  5  destination register
- wdata_i  in  32  ALU result for non-memory ops
- meme_i  in  1  memory access request
- memrw_i  in  1  0=read, 1=write
- memsigned_i  in  1  1=sign-extend load
- memwide_i  in  2  00=none, 01=8b, 10=16b, 11=32b
- memaddr_i  in  ADDR_W  byte address
- memdata_i  in  32  store data
- mem_din_i  in  8  RAM read data, valid the cycle after its address
- mem_a_o  out  ADDR_W  RAM address
- mem_dout_o  out  8  RAM write data
- mem_wr_o  out  1  RAM write strobe
- stall_req_o  out  1  hold EX/MEM latch and all upstream stages
- we_o  out  1  writeback enable
- wd_o  out  5  writeback register
- wdata_o  out  32  writeback data
- fwd_we_o  out  1  forwarding copy of we_o
- fwd_wd_o  out  5  forwarding copy of wd_o
- fwd_wdata_o  out  32  forwarding copy of wdata_o

Behaviour:
- Reset: rst is synchronous, active-high.
  - Next edge: state=IDLE, cnt=0, latched request and assembly register cleared.
  - While rst=1, all outputs are forced to 0 combinationally, so no write can fire during reset.
- Byte count N: 1/2/4 for memwide 01/10/11.
- A request with meme_i=1 and memwide=00 is treated as a non-memory op.
- IDLE, meme_i=0:
  - we_o=we_i, wd_o=wd_i, wdata_o=wdata_i, stall_req_o=0.
  - RAM outputs are 0.
- IDLE, meme_i=1 (start cycle):
  - Latch we/wd/rw/signed/N/addr/data.
  - cnt<=0, go BUSY.
  - stall_req_o=1, we_o=0.
- BUSY, write:
  - At cnt=k (k<N): mem_a_o=addr+k, mem_wr_o=1, mem_dout_o=data[8k+7:8k].
  - At k=N-1, go DONE.
- BUSY, read:
  - At cnt=k (k<N): mem_a_o=addr+k, mem_wr_o=0.
  - At cnt=k with k>=1: capture mem_din_i into byte k-1 of the assembly register.
  - At cnt=N: capture only, mem_a_o=0; go DONE.
- BUSY: stall_req_o=1, we_o=0.
- Address arithmetic: addr+k is modulo 2^ADDR_W and wraps silently. No misalignment check; unaligned addresses are accessed bytewise.
- DONE (one cycle):
  - stall_req_o=0, we_o=latched we, wd_o=latched wd.
  - wdata_o = extended load value; 0 for stores.
  - Next state IDLE; the pipeline advances on this edge.
- Extension:
  - 8b: signed replicates bit7, else zero-fill.
  - 16b: signed replicates bit15, else zero-fill.
  - 32b: no extension.
- Stall window (start cycle through last BUSY cycle): write N+1 cycles, read N+2 cycles. The result appears in the following DONE cycle.
- Inputs are ignored outside IDLE; upstream holds them stable because of stall_req_o.
- Forwarding: fwd_* equal we_o/wd_o/wdata_o in every state, so they are 0 while stalled.
- Reset mid-access aborts the sequence. Partially written bytes remain in RAM, and no writeback occurs.

Decomposition:
- Shared defines header:
  - memwide encodings (Memory0bits..Memory32bits)
  - MemoryRead/MemoryWrite, MemorySignedExtend/MemoryNoSignedExtend
  - ForwardingEnable/Disable
  - RegBus/RegAddrBus widths
  - MEM state encodings IDLE/BUSY/DONE
- One combinational sub-module, mem_load_ext: width, signed, raw32 in; 32-bit extended result out.

Test Plan:
- Non-mem pass-through: we_i=1, wd_i=5, wdata_i=0x1234, meme_i=0 -> same cycle we_o=1, wd_o=5, wdata_o=0x1234, fwd_* equal, stall_req_o=0, mem_wr_o=0.
- SW store: addr=0x100, data=0xAABBCCDD -> writes 0xDD@0x100, 0xCC@0x101, 0xBB@0x102, 0xAA@0x103 in 4 consecutive BUSY cycles; stall high 5 cycles; DONE has we_o=0.
- LB signed: RAM[0x20]=0x80, wd=3 -> stall high 3 cycles; DONE wdata_o=0xFFFFFF80, we_o=1, wd_o=3. LBU from the same address -> 0x00000080.
- LH signed and LW: RAM[0x40..0x43]=0x34,0x82,0x56,0x78 -> LH@0x40 gives 0xFFFF8234; LW@0x40 gives 0x78568234 with stall high 6 cycles.
- Address wrap: SH at addr=0xFFFFFFFF, data=0x1122 -> 0x22@0xFFFFFFFF, then 0x11@0x00000000.
- Reset mid-SW: assert rst during the 2nd BUSY cycle -> mem_wr_o=0 immediately. After the edge: IDLE, stall_req_o=0, we_o=0. A following non-mem instruction passes through normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access widths, direction/sign flags,
// bus widths and the byte-serial sequencer state type.
package mem_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [1:0] Memory0bits  = 2'b00;
  localparam logic [1:0] Memory8bits  = 2'b01;
  localparam logic [1:0] Memory16bits = 2'b10;
  localparam logic [1:0] Memory32bits = 2'b11;

  localparam logic MemoryRead  = 1'b0;
  localparam logic MemoryWrite = 1'b1;

  localparam logic MemorySignedExtend   = 1'b1;
  localparam logic MemoryNoSignedExtend = 1'b0;

  localparam logic ForwardingEnable  = 1'b1;
  localparam logic ForwardingDisable = 1'b0;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  // Number of RAM bytes touched by one access of the given width.
  function automatic logic [2:0] n_bytes(input logic [1:0] wide);
    case (wide)
      Memory8bits:  n_bytes = 3'd1;
      Memory16bits: n_bytes = 3'd2;
      Memory32bits: n_bytes = 3'd4;
      default:      n_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of an assembled little-endian load value to RegBus bits.
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [1:0]        width,
  input  logic              sign_ext,
  input  logic [RegBus-1:0] raw,
  output logic [RegBus-1:0] ext
);

  always_comb begin
    ext = raw;
    case (width)
      Memory8bits:  ext = {{(RegBus-8){sign_ext & raw[7]}}, raw[7:0]};
      Memory16bits: ext = {{(RegBus-16){sign_ext & raw[15]}}, raw[15:0]};
      default:      ext = raw;
    endcase
  end

endmodule

// File: rtl/mem.sv
// MEM pipeline stage: turns one load/store into a byte-serial sequence on an
// 8-bit synchronous RAM and produces the writeback/forwarding triple.
module mem
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [RegAddrBus-1:0] wd_i,
  input  logic [RegBus-1:0]     wdata_i,
  input  logic                  meme_i,
  input  logic                  memrw_i,
  input  logic                  memsigned_i,
  input  logic [1:0]            memwide_i,
  input  logic [ADDR_W-1:0]     memaddr_i,
  input  logic [RegBus-1:0]     memdata_i,
  input  logic [7:0]            mem_din_i,
  output logic [ADDR_W-1:0]     mem_a_o,
  output logic [7:0]            mem_dout_o,
  output logic                  mem_wr_o,
  output logic                  stall_req_o,
  output logic                  we_o,
  output logic [RegAddrBus-1:0] wd_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic                  fwd_we_o,
  output logic [RegAddrBus-1:0] fwd_wd_o,
  output logic [RegBus-1:0]     fwd_wdata_o
);

  // Stall handshake: while stall_req_o=1 upstream holds every EX/MEM input
  // stable; the request is consumed on the first edge with stall_req_o=0.

  mem_state_e            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  lat_we;
  logic [RegAddrBus-1:0] lat_wd;
  logic                  lat_rw;
  logic                  lat_signed;
  logic [1:0]            lat_wide;
  logic [ADDR_W-1:0]     lat_addr;
  logic [RegBus-1:0]     lat_data;
  logic [RegBus-1:0]     asm_q;

  logic [2:0]            lat_n;
  logic [2:0]            lat_last;
  logic [1:0]            cap_idx;
  logic [RegBus-1:0]     ext_val;

  logic                  start;
  logic                  capture;
  logic                  stall;
  logic                  out_we;
  logic [RegAddrBus-1:0] out_wd;
  logic [RegBus-1:0]     out_wdata;
  logic [ADDR_W-1:0]     out_a;
  logic [7:0]            out_dout;
  logic                  out_wr;

  assign lat_n    = n_bytes(lat_wide);
  assign lat_last = lat_n - 3'd1;
  // RAM data lags its address by one cycle, so count k fills byte k-1.
  assign cap_idx  = 2'(cnt_q - 3'd1);

  mem_load_ext u_load_ext (
    .width    (lat_wide),
    .sign_ext (lat_signed),
    .raw      (asm_q),
    .ext      (ext_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MEM_IDLE;
      cnt_q      <= 3'd0;
      lat_we     <= 1'b0;
      lat_wd     <= '0;
      lat_rw     <= MemoryRead;
      lat_signed <= MemoryNoSignedExtend;
      lat_wide   <= Memory0bits;
      lat_addr   <= '0;
      lat_data   <= '0;
      asm_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        lat_we     <= we_i;
        lat_wd     <= wd_i;
        lat_rw     <= memrw_i;
        lat_signed <= memsigned_i;
        lat_wide   <= memwide_i;
        lat_addr   <= memaddr_i;
        lat_data   <= memdata_i;
        asm_q      <= '0;
      end
      if (capture) begin
        asm_q[{cap_idx, 3'b000} +: 8] <= mem_din_i;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start     = 1'b0;
    capture   = 1'b0;
    stall     = 1'b0;
    out_we    = 1'b0;
    out_wd    = '0;
    out_wdata = '0;
    out_a     = '0;
    out_dout  = 8'h00;
    out_wr    = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        // A zero-width request carries no memory work and passes through.
        if (meme_i && (memwide_i != Memory0bits)) begin
          start   = 1'b1;
          stall   = 1'b1;
          cnt_d   = 3'd0;
          state_d = MEM_BUSY;
        end else begin
          out_we    = we_i;
          out_wd    = wd_i;
          out_wdata = wdata_i;
        end
      end
      MEM_BUSY: begin
        stall = 1'b1;
        if (lat_rw == MemoryWrite) begin
          out_a    = lat_addr + ADDR_W'(cnt_q);
          out_wr   = 1'b1;
          out_dout = lat_data[{cnt_q[1:0], 3'b000} +: 8];
          if (cnt_q == lat_last) state_d = MEM_DONE;
          else                   cnt_d   = cnt_q + 3'd1;
        end else begin
          if (cnt_q < lat_n) out_a = lat_addr + ADDR_W'(cnt_q);
          if (cnt_q != 3'd0) capture = 1'b1;
          if (cnt_q == lat_n) state_d = MEM_DONE;
          else                cnt_d   = cnt_q + 3'd1;
        end
      end
      MEM_DONE: begin
        out_we    = lat_we;
        out_wd    = lat_wd;
        out_wdata = (lat_rw == MemoryRead) ? ext_val : '0;
        state_d   = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // Reset masks every output so no RAM write can fire while rst is high.
  assign stall_req_o = rst ? 1'b0 : stall;
  assign we_o        = rst ? 1'b0 : out_we;
  assign wd_o        = rst ? '0   : out_wd;
  assign wdata_o     = rst ? '0   : out_wdata;
  assign mem_a_o     = rst ? '0   : out_a;
  assign mem_dout_o  = rst ? 8'h00 : out_dout;
  assign mem_wr_o    = rst ? 1'b0 : out_wr;

  assign fwd_we_o    = we_o;
  assign fwd_wd_o    = wd_o;
  assign fwd_wdata_o = wdata_o;

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for the MEM stage: per-cycle expected-output queue built
// from a transaction-level model, plus literal checks of RAM and load results.
module tb_mem;

  localparam int ADDR_W = 32;
  localparam int EW     = 80;

  typedef struct packed {
    logic        stall;
    logic        we;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic [31:0] a;
    logic [7:0]  dout;
    logic        wr;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              we_i;
  logic [4:0]        wd_i;
  logic [31:0]       wdata_i;
  logic              meme_i;
  logic              memrw_i;
  logic              memsigned_i;
  logic [1:0]        memwide_i;
  logic [ADDR_W-1:0] memaddr_i;
  logic [31:0]       memdata_i;
  logic [7:0]        mem_din_i;
  logic [ADDR_W-1:0] mem_a_o;
  logic [7:0]        mem_dout_o;
  logic              mem_wr_o;
  logic              stall_req_o;
  logic              we_o;
  logic [4:0]        wd_o;
  logic [31:0]       wdata_o;
  logic              fwd_we_o;
  logic [4:0]        fwd_wd_o;
  logic [31:0]       fwd_wdata_o;

  mem #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we_i),
    .wd_i        (wd_i),
    .wdata_i     (wdata_i),
    .meme_i      (meme_i),
    .memrw_i     (memrw_i),
    .memsigned_i (memsigned_i),
    .memwide_i   (memwide_i),
    .memaddr_i   (memaddr_i),
    .memdata_i   (memdata_i),
    .mem_din_i   (mem_din_i),
    .mem_a_o     (mem_a_o),
    .mem_dout_o  (mem_dout_o),
    .mem_wr_o    (mem_wr_o),
    .stall_req_o (stall_req_o),
    .we_o        (we_o),
    .wd_o        (wd_o),
    .wdata_o     (wdata_o),
    .fwd_we_o    (fwd_we_o),
    .fwd_wd_o    (fwd_wd_o),
    .fwd_wdata_o (fwd_wdata_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM seen by the DUT (indexed by low 12 address bits) ----------------
  logic [7:0] ram       [4096];
  logic [7:0] model_ram [4096];

  always @(posedge clk) begin
    if (mem_wr_o) ram[mem_a_o[11:0]] <= mem_dout_o;
    mem_din_i <= ram[mem_a_o[11:0]];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  exp_t cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("stall_req", 32'(stall_req_o), 32'(cur.stall));
      chk("we",        32'(we_o),        32'(cur.we));
      chk("wd",        32'(wd_o),        32'(cur.wd));
      chk("wdata",     wdata_o,          cur.wdata);
      chk("fwd_we",    32'(fwd_we_o),    32'(cur.we));
      chk("fwd_wd",    32'(fwd_wd_o),    32'(cur.wd));
      chk("fwd_wdata", fwd_wdata_o,      cur.wdata);
      chk("mem_a",     mem_a_o,          cur.a);
      chk("mem_dout",  32'(mem_dout_o),  32'(cur.dout));
      chk("mem_wr",    32'(mem_wr_o),    32'(cur.wr));
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ext_model(input logic [1:0] wide, input logic sgn,
                                            input logic [31:0] raw);
    logic [31:0] v;
    if (wide == 2'b01) begin
      v = raw % 256;
      if (sgn && v >= 128) v = v - 256;
    end else if (wide == 2'b10) begin
      v = raw % 65536;
      if (sgn && v >= 32768) v = v - 65536;
    end else begin
      v = raw;
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [7:0] val);
    ram[addr[11:0]]       = val;
    model_ram[addr[11:0]] = val;
  endtask

  task automatic nonmem(input logic we, input logic [4:0] wd, input logic [31:0] wdata);
    exp_t e;
    meme_i  = 1'b0;
    we_i    = we;
    wd_i    = wd;
    wdata_i = wdata;
    e       = '0;
    e.we    = we;
    e.wd    = wd;
    e.wdata = wdata;
    step(e);
  endtask

  task automatic memop(input logic rw, input logic sgn, input logic [1:0] wide,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic we, input logic [4:0] wd,
                       output logic [31:0] result);
    exp_t        e;
    int          n;
    logic [31:0] ak;
    logic [31:0] raw;
    meme_i      = 1'b1;
    memrw_i     = rw;
    memsigned_i = sgn;
    memwide_i   = wide;
    memaddr_i   = addr;
    memdata_i   = data;
    we_i        = we;
    wd_i        = wd;
    wdata_i     = 32'hDEAD_BEEF;
    n = (wide == 2'b01) ? 1 : (wide == 2'b10) ? 2 : 4;
    e = '0; e.stall = 1'b1;
    step(e);
    raw = '0;
    for (int k = 0; k < n; k++) begin
      ak = addr + 32'(k);
      e = '0; e.stall = 1'b1; e.a = ak;
      if (rw) begin
        e.dout = 8'(data >> (8 * k));
        e.wr   = 1'b1;
        model_ram[ak[11:0]] = e.dout;
      end else begin
        raw = raw | (32'(model_ram[ak[11:0]]) << (8 * k));
      end
      step(e);
    end
    if (!rw) begin
      e = '0; e.stall = 1'b1;
      step(e);
    end
    e = '0; e.we = we; e.wd = wd;
    e.wdata = rw ? 32'h0 : ext_model(wide, sgn, raw);
    result = e.wdata;
    meme_i = 1'b0;
    step(e);
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] res;
  exp_t        ez;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]       = 8'h00;
      model_ram[i] = 8'h00;
    end
    rst = 1'b1; we_i = 1'b0; wd_i = '0; wdata_i = '0; meme_i = 1'b0;
    memrw_i = 1'b0; memsigned_i = 1'b0; memwide_i = 2'b00; memaddr_i = '0; memdata_i = '0;
    @(posedge clk); #1;
    ez = '0;
    meme_i = 1'b1; memwide_i = 2'b11; memrw_i = 1'b1; we_i = 1'b1; wdata_i = 32'h5555_5555;
    step(ez);
    step(ez);
    rst = 1'b0;

    // pass-through, including a meme request with zero width
    nonmem(1'b1, 5'd5, 32'h0000_1234);
    nonmem(1'b0, 5'd9, 32'hFFFF_FFFF);
    meme_i = 1'b1; memwide_i = 2'b00; we_i = 1'b1; wd_i = 5'd2; wdata_i = 32'h0BAD_F00D;
    ez = '0; ez.we = 1'b1; ez.wd = 5'd2; ez.wdata = 32'h0BAD_F00D;
    step(ez);

    // SW
    memop(1'b1, 1'b0, 2'b11, 32'h0000_0100, 32'hAABB_CCDD, 1'b0, 5'd0, res);
    chk("sw_done_wdata", res, 32'h0);
    chk("sw_ram_100", 32'(ram[12'h100]), 32'hDD);
    chk("sw_ram_101", 32'(ram[12'h101]), 32'hCC);
    chk("sw_ram_102", 32'(ram[12'h102]), 32'hBB);
    chk("sw_ram_103", 32'(ram[12'h103]), 32'hAA);

    // LB / LBU
    preload(32'h20, 8'h80);
    memop(1'b0, 1'b1, 2'b01, 32'h0000_0020, 32'h0, 1'b1, 5'd3, res);
    chk("lb_value", res, 32'hFFFF_FF80);
    memop(1'b0, 1'b0, 2'b01, 32'h0000_0020, 32'h0, 1'b1, 5'd4, res);
    chk("lbu_value", res, 32'h0000_0080);

    // LH / LHU / LW
    preload(32'h40, 8'h34);
    preload(32'h41, 8'h82);
    preload(32'h42, 8'h56);
    preload(32'h43, 8'h78);
    memop(1'b0, 1'b1, 2'b10, 32'h0000_0040, 32'h0, 1'b1, 5'd6, res);
    chk("lh_value", res, 32'hFFFF_8234);
    memop(1'b0, 1'b0, 2'b10, 32'h0000_0040, 32'h0, 1'b1, 5'd8, res);
    chk("lhu_value", res, 32'h0000_8234);
    memop(1'b0, 1'b1, 2'b11, 32'h0000_0040, 32'h0, 1'b1, 5'd7, res);
    chk("lw_value", res, 32'h7856_8234);

    // SH across the top of the address space
    memop(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'h0000_1122, 1'b0, 5'd0, res);
    chk("sh_wrap_hi", 32'(ram[12'hFFF]), 32'h22);
    chk("sh_wrap_lo", 32'(ram[12'h000]), 32'h11);

    // reset during the second BUSY cycle of a SW
    meme_i = 1'b1; memrw_i = 1'b1; memsigned_i = 1'b0; memwide_i = 2'b11;
    memaddr_i = 32'h0000_0200; memdata_i = 32'h5566_7788; we_i = 1'b0; wd_i = 5'd0;
    ez = '0; ez.stall = 1'b1;
    step(ez);
    ez = '0; ez.stall = 1'b1; ez.a = 32'h200; ez.dout = 8'h88; ez.wr = 1'b1;
    model_ram[12'h200] = 8'h88;
    step(ez);
    rst = 1'b1;
    ez = '0;
    step(ez);
    rst = 1'b0;
    nonmem(1'b1, 5'd7, 32'h0000_CAFE);
    chk("abort_ram_200", 32'(ram[12'h200]), 32'h88);
    chk("abort_ram_201", 32'(ram[12'h201]), 32'h00);
    memop(1'b0, 1'b0, 2'b11, 32'h0000_0200, 32'h0, 1'b1, 5'd10, res);
    chk("abort_lw_value", res, 32'h0000_0088);

    nonmem(1'b0, 5'd0, 32'h0);
    nonmem(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
